// File: rtl/sonic_vc_tx_pkg.sv
// Shared constants and state encoding for the VC TX arbiter.
package sonic_vc_tx_pkg;

  localparam int DATA_WIDTH = 133;
  localparam int SOP_BIT    = DATA_WIDTH - 1;
  localparam int EOP_BIT    = DATA_WIDTH - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/sonic_vc_tx_arbiter_if.sv
// Per-channel FIFO heads in, merged registered beat stream out.
interface sonic_vc_tx_arbiter_if #(
  parameter int N_CH       = 4,
  parameter int FILL_WIDTH = 4,
  parameter int CH_W       = 3
);
  import sonic_vc_tx_pkg::*;

  logic [N_CH-1:0]            in_valid;
  logic [N_CH-1:0]            in_ready;
  logic [N_CH*DATA_WIDTH-1:0] in_data;
  logic [N_CH*FILL_WIDTH-1:0] in_fill;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [CH_W-1:0]            out_ch;

  modport master (
    output in_valid, in_data, in_fill, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_fill, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/sonic_vc_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module sonic_vc_rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 3
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_last,
  output logic            o_found,
  output logic [CH_W-1:0] o_idx
);

  int w_c;

  // Walk distances from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_c     = 0;
    for (int k = N_CH; k >= 1; k--) begin
      w_c = (int'(i_last) + k) % N_CH;
      if (i_req[w_c]) begin
        o_found = 1'b1;
        o_idx   = CH_W'(w_c);
      end
    end
  end

endmodule

// File: rtl/sonic_vc_tx_arbiter.sv
// Packet-atomic round-robin merge of N_CH VC FIFOs into one registered beat stream.
// Optional per-channel packet counters under SONIC_VC_TX_ARB_STATS_EN.
module sonic_vc_tx_arbiter #(
  parameter int N_CH       = 4,
  parameter int FILL_WIDTH = 4,
  parameter int MIN_FILL   = 1,
  parameter int CH_W       = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sonic_vc_tx_arbiter_if.slave bus,
  input  logic [N_CH-1:0]      i_ch_en,
  output logic                 o_busy,
  output logic                 o_err_sop,
  input  logic [CH_W-1:0]      i_stat_sel,
  input  logic                 i_stat_clr,
  output logic [31:0]          o_stat_pkt_cnt
);
  import sonic_vc_tx_pkg::*;

  state_t                r_state, w_state_nxt;
  logic [CH_W-1:0]       r_grant, w_grant_nxt;
  logic [CH_W-1:0]       r_last_grant, w_last_nxt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]       r_out_ch;
  logic                  r_err_sop, w_err_nxt;

  logic [N_CH-1:0]       w_elig, w_bad_head, w_in_ready;
  logic                  w_found;
  logic [CH_W-1:0]       w_pick;
  logic [DATA_WIDTH-1:0] w_beat;
  logic                  w_gvalid, w_slot_free, w_load;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_elig[i] = i_ch_en[i] && bus.in_valid[i] && bus.in_data[i*DATA_WIDTH + SOP_BIT]
                  && (bus.in_fill[i*FILL_WIDTH +: FILL_WIDTH] >= FILL_WIDTH'(MIN_FILL));
      w_bad_head[i] = i_ch_en[i] && bus.in_valid[i] && !bus.in_data[i*DATA_WIDTH + SOP_BIT];
    end
  end

  sonic_vc_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .i_req   (w_elig),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    w_beat   = '0;
    w_gvalid = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == r_grant) begin
        w_beat   = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_gvalid = bus.in_valid[i];
      end
    end
  end

  assign w_slot_free = !r_out_valid || bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_in_ready  = '0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = BURST;
        end else begin
          // Descending walk leaves the lowest-index malformed head as the one popped.
          for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_bad_head[i]) begin
              w_in_ready    = '0;
              w_in_ready[i] = 1'b1;
              w_err_nxt     = 1'b1;
            end
          end
        end
      end
      BURST: begin
        for (int i = 0; i < N_CH; i++) begin
          if (CH_W'(i) == r_grant) w_in_ready[i] = w_slot_free;
        end
        w_load = w_gvalid && w_slot_free;
        if (w_load && w_beat[EOP_BIT]) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_W'(N_CH - 1);
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_err_sop    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_err_sop    <= w_err_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat;
        r_out_ch    <= r_grant;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Keep FIFOs untouched while reset is held, even if a malformed head is present.
  assign bus.in_ready  = w_in_ready & {N_CH{reset_n}};
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign o_busy        = (r_state == BURST);
  assign o_err_sop     = r_err_sop;

`ifdef SONIC_VC_TX_ARB_STATS_EN
  logic [31:0] r_pkt_cnt [N_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) r_pkt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (i_stat_clr)
          r_pkt_cnt[i] <= '0;
        else if (w_load && w_beat[EOP_BIT] && (CH_W'(i) == r_grant))
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    o_stat_pkt_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == i_stat_sel) o_stat_pkt_cnt = r_pkt_cnt[i];
    end
  end
`else
  logic w_stat_unused;
  assign w_stat_unused  = ^{i_stat_sel, i_stat_clr};
  assign o_stat_pkt_cnt = '0;
`endif

endmodule
